// File: rtl/scaler_cfg_ctrl_if.sv
// Host configuration bus of scaler_cfg_ctrl.
// Handshake: the host pulses cfg_wr for one cycle with cfg_step/cfg_w/cfg_h
// valid in that same cycle. The request is taken only while cfg_busy is low.
// A cfg_wr seen while cfg_busy is high is dropped (no queueing). cfg_err
// reports that the most recent accepted request was rejected.
interface scaler_cfg_ctrl_if #(
    parameter int DIM_WIDTH = 16
);
    logic                 cfg_wr;
    logic [15:0]          cfg_step;
    logic [DIM_WIDTH-1:0] cfg_w;
    logic [DIM_WIDTH-1:0] cfg_h;
    logic                 cfg_busy;
    logic                 cfg_err;

    modport master (
        output cfg_wr, cfg_step, cfg_w, cfg_h,
        input  cfg_busy, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_step, cfg_w, cfg_h,
        output cfg_busy, cfg_err
    );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// Configuration sequencer and output-geometry checker for the
// scaler_h -> scaler_v chain. A host request is turned into output line size
// and line count by an iterative accumulator, then committed at the next input
// frame boundary (vs_i rise). The scaler_v output stream is measured against
// the committed geometry.
// Optional statistics counters are built when SCALER_CFG_CTRL_STAT_EN is
// defined; otherwise stat_frames and stat_last_w are tied to 0.
module scaler_cfg_ctrl #(
    parameter int STEP          = 4096,
    parameter int LINE_SIZE_MAX = 150,
    parameter int DIM_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scaler_cfg_ctrl_if.slave     cfg,
    input  logic                 vs_i,
    output logic [15:0]          scale_step,
    output logic [DIM_WIDTH-1:0] scale_line_size,
    output logic [DIM_WIDTH-1:0] scale_frame_h,
    output logic                 apply_o,
    input  logic                 de_o,
    input  logic                 hs_o,
    input  logic                 vs_o,
    output logic                 err_line,
    output logic                 err_frame,
    input  logic                 err_clr,
    output logic [15:0]          stat_frames,
    output logic [DIM_WIDTH-1:0] stat_last_w,
    output logic [1:0]           dbg_state
);
    localparam int PW = DIM_WIDTH + 16;   // dim * STEP
    localparam int AW = DIM_WIDTH + 17;   // accumulator, headroom of one step
    localparam int IW = $clog2(LINE_SIZE_MAX + 3);
    localparam logic [15:0]          STEP_W  = 16'(STEP);
    localparam logic [DIM_WIDTH-1:0] N_MAX   = DIM_WIDTH'(LINE_SIZE_MAX + 1);
    localparam logic [IW-1:0]        GUARD   = IW'(LINE_SIZE_MAX + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          req_step_q, req_step_d;
    logic [DIM_WIDTH-1:0] req_w_q, req_w_d, req_h_q, req_h_d;
    logic [AW-1:0]        acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [DIM_WIDTH-1:0] n_x_q, n_x_d, n_y_q, n_y_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [15:0]          scale_step_q, scale_step_d;
    logic [DIM_WIDTH-1:0] line_size_q, line_size_d, frame_h_q, frame_h_d;
    logic                 apply_q, apply_d;
    logic                 vs_i_q;

    logic [PW-1:0]        tgt_x, tgt_y;
    logic                 done_x, done_y;
    logic                 cfg_err_set;
    logic                 commit;

    // Targets dim*STEP held at full precision so ceil(dim*STEP/step) is exact
    assign tgt_x  = PW'(req_w_q) * PW'(STEP);
    assign tgt_y  = PW'(req_h_q) * PW'(STEP);
    assign done_x = acc_x_q >= AW'(tgt_x);
    assign done_y = acc_y_q >= AW'(tgt_y);

    // Sequencer next-state: request latch, iterative division, frame-boundary commit
    always_comb begin
        state_d      = state_q;
        req_step_d   = req_step_q;
        req_w_d      = req_w_q;
        req_h_d      = req_h_q;
        acc_x_d      = acc_x_q;
        acc_y_d      = acc_y_q;
        n_x_d        = n_x_q;
        n_y_d        = n_y_q;
        iter_d       = iter_q;
        scale_step_d = scale_step_q;
        line_size_d  = line_size_q;
        frame_h_d    = frame_h_q;
        apply_d      = 1'b0;
        cfg_err_set  = 1'b0;
        commit       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_wr) begin
                    req_step_d = cfg.cfg_step;
                    req_w_d    = cfg.cfg_w;
                    req_h_d    = cfg.cfg_h;
                    if (cfg.cfg_step == '0 || cfg.cfg_w == '0 || cfg.cfg_h == '0) begin
                        cfg_err_set = 1'b1;
                    end else begin
                        acc_x_d = '0;
                        acc_y_d = '0;
                        n_x_d   = '0;
                        n_y_d   = '0;
                        iter_d  = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (done_x && done_y) begin
                    if (n_x_q > N_MAX || n_y_q > N_MAX) begin
                        cfg_err_set = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = PEND;
                    end
                end else if (iter_q == GUARD) begin
                    // Result cannot be legal any more; stop burning cycles
                    cfg_err_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    if (!done_x) begin
                        acc_x_d = acc_x_q + AW'(req_step_q);
                        n_x_d   = n_x_q + 1'b1;
                    end
                    if (!done_y) begin
                        acc_y_d = acc_y_q + AW'(req_step_q);
                        n_y_d   = n_y_q + 1'b1;
                    end
                    iter_d = iter_q + 1'b1;
                end
            end
            PEND: begin
                if (vs_i && !vs_i_q) begin
                    scale_step_d = req_step_q;
                    line_size_d  = n_x_q - 1'b1;
                    frame_h_d    = n_y_q;
                    apply_d      = 1'b1;
                    commit       = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cfg_err_d = err_clr ? 1'b0 : (cfg_err_q | cfg_err_set);
    end

    // Sequencer state and committed configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_step_q   <= '0;
            req_w_q      <= '0;
            req_h_q      <= '0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            n_x_q        <= '0;
            n_y_q        <= '0;
            iter_q       <= '0;
            cfg_err_q    <= 1'b0;
            scale_step_q <= STEP_W;
            line_size_q  <= '0;
            frame_h_q    <= '0;
            apply_q      <= 1'b0;
            vs_i_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_step_q   <= req_step_d;
            req_w_q      <= req_w_d;
            req_h_q      <= req_h_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            n_x_q        <= n_x_d;
            n_y_q        <= n_y_d;
            iter_q       <= iter_d;
            cfg_err_q    <= cfg_err_d;
            scale_step_q <= scale_step_d;
            line_size_q  <= line_size_d;
            frame_h_q    <= frame_h_d;
            apply_q      <= apply_d;
            vs_i_q       <= vs_i;
        end
    end

    // ---------------- output stream checker ----------------
    logic                 hs_q, vs_q;
    logic [DIM_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [DIM_WIDTH-1:0] frame_lines_q, frame_lines_d;
    logic                 skip_q, skip_d;
    logic                 err_line_q, err_line_d, err_frame_q, err_frame_d;
    logic                 hs_rise, vs_rise, chk_en, line_done;
    logic [DIM_WIDTH-1:0] lines_now;

    assign hs_rise   = hs_o && !hs_q;
    assign vs_rise   = vs_o && !vs_q;
    assign chk_en    = frame_h_q != '0;
    assign line_done = hs_rise && (line_cnt_q != '0);
    assign lines_now = frame_lines_q + DIM_WIDTH'(line_done);

    // Checker next-state: per-line de count, per-frame line count, sticky errors
    always_comb begin
        line_cnt_d    = hs_rise ? '0 : line_cnt_q + DIM_WIDTH'(de_o);
        frame_lines_d = vs_rise ? '0 : lines_now;
        // The frame in flight at a commit was built with the old geometry
        skip_d        = commit ? 1'b1 : (vs_rise ? 1'b0 : skip_q);
        err_line_d    = err_line_q;
        err_frame_d   = err_frame_q;
        if (line_done && chk_en && line_cnt_q != line_size_q + 1'b1) begin
            err_line_d = 1'b1;
        end
        if (vs_rise && chk_en && !skip_q && lines_now != frame_h_q) begin
            err_frame_d = 1'b1;
        end
        if (err_clr) begin
            err_line_d  = 1'b0;
            err_frame_d = 1'b0;
        end
    end

    // Checker registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            line_cnt_q    <= '0;
            frame_lines_q <= '0;
            skip_q        <= 1'b0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
        end else begin
            hs_q          <= hs_o;
            vs_q          <= vs_o;
            line_cnt_q    <= line_cnt_d;
            frame_lines_q <= frame_lines_d;
            skip_q        <= skip_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
        end
    end

`ifdef SCALER_CFG_CTRL_STAT_EN
    logic [15:0]          stat_frames_q, stat_frames_d;
    logic [DIM_WIDTH-1:0] stat_last_w_q, stat_last_w_d;

    // Statistics next-state: frame counter wraps, last line length on line end
    always_comb begin
        stat_frames_d = vs_rise ? stat_frames_q + 1'b1 : stat_frames_q;
        stat_last_w_d = line_done ? line_cnt_q : stat_last_w_q;
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_q <= '0;
            stat_last_w_q <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_last_w_q <= stat_last_w_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_last_w = stat_last_w_q;
`else
    assign stat_frames = '0;
    assign stat_last_w = '0;
`endif

    assign cfg.cfg_busy    = state_q != IDLE;
    assign cfg.cfg_err     = cfg_err_q;
    assign scale_step      = scale_step_q;
    assign scale_line_size = line_size_q;
    assign scale_frame_h   = frame_h_q;
    assign apply_o         = apply_q;
    assign err_line        = err_line_q;
    assign err_frame       = err_frame_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// Directed bench for scaler_cfg_ctrl: configuration sequencing, commit timing,
// request rejection, output geometry checking and reset during a pending commit.
module tb_scaler_cfg_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs_i = 1'b0;
    logic        de_o = 1'b0, hs_o = 1'b0, vs_o = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] scale_step;
    logic [15:0] scale_line_size, scale_frame_h;
    logic        apply_o, err_line, err_frame;
    logic [15:0] stat_frames, stat_last_w;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int apply_cnt = 0;

    scaler_cfg_ctrl_if #(.DIM_WIDTH(16)) cfg_bus ();

    scaler_cfg_ctrl #(.STEP(4096), .LINE_SIZE_MAX(150), .DIM_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg_bus.slave), .vs_i(vs_i),
        .scale_step(scale_step), .scale_line_size(scale_line_size),
        .scale_frame_h(scale_frame_h), .apply_o(apply_o),
        .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .err_line(err_line), .err_frame(err_frame), .err_clr(err_clr),
        .stat_frames(stat_frames), .stat_last_w(stat_last_w), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (apply_o === 1'b1) apply_cnt <= apply_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [15:0] s, input logic [15:0] w, input logic [15:0] h);
        cfg_bus.cfg_wr = 1'b1;
        cfg_bus.cfg_step = s;
        cfg_bus.cfg_w = w;
        cfg_bus.cfg_h = h;
        tick();
        cfg_bus.cfg_wr = 1'b0;
    endtask

    task automatic wait_pend(input string tag);
        int n = 0;
        while (dbg_state !== 2'd2 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, dbg_state === 2'd2}, 32'd1);
    endtask

    task automatic pulse_vs_i();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    task automatic drive_line(input int n);
        for (int i = 0; i < n; i++) begin
            de_o = 1'b1;
            tick();
        end
        de_o = 1'b0;
        hs_o = 1'b1;
        tick();
        hs_o = 1'b0;
        tick();
    endtask

    task automatic drive_vs();
        vs_o = 1'b1;
        tick();
        vs_o = 1'b0;
        tick();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        int n;
        int a0;
        cfg_bus.cfg_wr = 1'b0;
        cfg_bus.cfg_step = '0;
        cfg_bus.cfg_w = '0;
        cfg_bus.cfg_h = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_step", scale_step, 4096);
        chk("rst_line_size", scale_line_size, 0);
        chk("rst_frame_h", scale_frame_h, 0);
        chk("rst_busy", cfg_bus.cfg_busy, 0);
        chk("rst_cfg_err", cfg_bus.cfg_err, 0);
        chk("rst_apply", apply_o, 0);
        chk("rst_err_line", err_line, 0);
        chk("rst_err_frame", err_frame, 0);
        chk("rst_state", dbg_state, 0);

        // 25x25 at step 0.5 -> 50x50; CALC takes 50 iterations plus the done cycle
        cfg_write(16'd2048, 16'd25, 16'd25);
        chk("calc_busy", cfg_bus.cfg_busy, 1);
        n = 0;
        while (dbg_state === 2'd1 && n < 300) begin
            tick();
            n++;
        end
        chk("calc_cycles_le52", {31'd0, n <= 52}, 32'd1);
        chk("calc_to_pend", dbg_state, 2);
        repeat (4) tick();
        chk("pend_no_apply", apply_o, 0);
        chk("pend_step_held", scale_step, 4096);
        chk("pend_busy", cfg_bus.cfg_busy, 1);
        vs_i = 1'b1;
        tick();
        chk("c1_apply", apply_o, 1);
        chk("c1_line_size", scale_line_size, 49);
        chk("c1_frame_h", scale_frame_h, 50);
        chk("c1_step", scale_step, 2048);
        chk("c1_busy", cfg_bus.cfg_busy, 0);
        vs_i = 1'b0;
        tick();
        chk("c1_apply_pulse", apply_o, 0);

        // 25x25 at step 2.0 -> ceil(12.5)=13; drive a matching frame
        cfg_write(16'd8192, 16'd25, 16'd25);
        wait_pend("c2_pend");
        pulse_vs_i();
        chk("c2_line_size", scale_line_size, 12);
        chk("c2_frame_h", scale_frame_h, 13);
        chk("c2_step", scale_step, 8192);
        drive_vs();
        for (int l = 0; l < 13; l++) drive_line(13);
        drive_vs();
        chk("c2_err_line", err_line, 0);
        chk("c2_err_frame", err_frame, 0);
`ifdef SCALER_CFG_CTRL_STAT_EN
        chk("stat_frames", stat_frames, 2);
        chk("stat_last_w", stat_last_w, 13);
`else
        chk("stat_frames_off", stat_frames, 0);
        chk("stat_last_w_off", stat_last_w, 0);
`endif

        // zero step rejected; err_clr wins over a same-cycle set
        a0 = apply_cnt;
        err_clr = 1'b1;
        cfg_write(16'd0, 16'd25, 16'd25);
        err_clr = 1'b0;
        chk("clr_priority", cfg_bus.cfg_err, 0);
        cfg_write(16'd0, 16'd25, 16'd25);
        chk("zero_step_err", cfg_bus.cfg_err, 1);
        chk("zero_step_idle", cfg_bus.cfg_busy, 0);
        pulse_vs_i();
        chk("zero_step_no_apply", apply_cnt, a0);
        chk("zero_step_kept", scale_line_size, 12);
        clear_err();
        chk("err_clr_cfg", cfg_bus.cfg_err, 0);

        // 100 px at step 0.25 -> 400 > 151: guard aborts
        a0 = apply_cnt;
        cfg_write(16'd1024, 16'd100, 16'd25);
        n = 0;
        while (cfg_bus.cfg_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("ovf_done", cfg_bus.cfg_busy, 0);
        chk("ovf_err", cfg_bus.cfg_err, 1);
        chk("ovf_state", dbg_state, 0);
        pulse_vs_i();
        chk("ovf_no_apply", apply_cnt, a0);
        chk("ovf_kept", scale_frame_h, 13);
        clear_err();

        // commit n_x=50, then short line and short frame
        cfg_write(16'd2048, 16'd25, 16'd25);
        wait_pend("c3_pend");
        pulse_vs_i();
        chk("c3_line_size", scale_line_size, 49);
        drive_vs();
        chk("c3_skip_frame", err_frame, 0);
        drive_line(49);
        chk("short_line", err_line, 1);
        drive_vs();
        chk("one_line_frame", err_frame, 1);
        clear_err();
        chk("clr_line", err_line, 0);
        chk("clr_frame", err_frame, 0);
        for (int l = 0; l < 49; l++) drive_line(50);
        chk("good_lines", err_line, 0);
        chk("frame_pre_vs", err_frame, 0);
        drive_vs();
        chk("short_frame", err_frame, 1);
        clear_err();

        // reset while a commit is pending
        cfg_write(16'd8192, 16'd25, 16'd25);
        wait_pend("c4_pend");
        rst_n = 1'b0;
        #3;
        chk("rst_pend_step", scale_step, 4096);
        chk("rst_pend_busy", cfg_bus.cfg_busy, 0);
        chk("rst_pend_frame_h", scale_frame_h, 0);
        tick();
        rst_n = 1'b1;
        tick();
        a0 = apply_cnt;
        pulse_vs_i();
        repeat (2) tick();
        chk("rst_pend_no_apply", apply_cnt, a0);
        chk("rst_pend_idle", dbg_state, 0);
        chk("rst_pend_step_after", scale_step, 4096);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
